// File: rtl/axi_wr_slave_pkg.sv
// Shared constants for the DDR2 write-channel front end.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
//
// Holds the DDR geometry that sizes the default address and data widths.
// It also holds the write-path FSM state codes and the AXI B response codes.
package axi_wr_slave_pkg;

  // DDR2 geometry; byte-independent address = row + column + bank.
  localparam int ROW_BITS = 13;
  localparam int COL_BITS = 10;
  localparam int BA_BITS  = 2;
  localparam int DQ_BITS  = 16;

  localparam int DEF_ADDR_WIDTH = ROW_BITS + COL_BITS + BA_BITS;
  // One core data word carries both DDR edges.
  localparam int DEF_DATA_WIDTH = DQ_BITS * 2;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_CMD  = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } wr_state_e;

  // A burst longer than the W buffer cannot be stored and forwarded.
  function automatic logic len_too_long(input logic [7:0] len, input int depth);
    return int'(len) > (depth - 1);
  endfunction

endpackage

// File: rtl/axi_wdata_fifo.sv
// Synchronous W-beat buffer with a registered read port.
// Latency: dout is valid one cycle after pop; a push is visible to pop on the next cycle.
// Backpressure: push is ignored when full, unless a pop happens in the same cycle; pop is ignored when empty.
//
// Ports: clk, rstn (async active-low), clr (synchronous flush), push/din,
//        pop/dout (registered, holds its value when no pop happens), full, empty.
module axi_wdata_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW_FIFO_LOG2 = $clog2(FIFO_DEPTH);
  localparam logic [AW_FIFO_LOG2:0] DEPTH_C = (AW_FIFO_LOG2 + 1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW_FIFO_LOG2-1:0] wr_ptr;
  logic [AW_FIFO_LOG2-1:0] rd_ptr;
  logic [AW_FIFO_LOG2:0]   count;
  logic                    do_push;
  logic                    do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the slot being written this cycle.
  assign do_push = push & (~full | do_pop);

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_pop) begin
        dout <= mem[rd_ptr];
      end
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi_wr_slave.sv
// AXI-style write responder: one AW burst at a time, W beats stored, then a single DDR2 core write command.
// Latency: AW->wready 1 cycle; last W beat->cmd_valid 1 cycle; wr_done->bvalid 1 cycle; wd_data 1 cycle after wd_rd_en.
// Backpressure: wready drops when the buffer is full; the next AW waits for B to complete; cmd and B hold until ready.
//
// Ports: AXI slave side  awvalid/awready/awaddr/awlen, wvalid/wready/wdata/wlast, bvalid/bready/bresp
//        DDR2 core side  cmd_valid/cmd_ready/cmd_addr/cmd_len, wd_rd_en/wd_data, wr_done
module axi_wr_slave
  import axi_wr_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  input  logic                  wd_rd_en,
  output logic [DATA_WIDTH-1:0] wd_data,
  input  logic                  wr_done
);

  wr_state_e  state, state_n;
  logic [7:0] beat_cnt;
  logic       err_len;
  logic       err_last;
  logic       aw_hs;
  logic       w_hs;
  logic       end_beat;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_flush;

  assign aw_hs      = awvalid & awready;
  assign w_hs       = wvalid & wready;
  assign end_beat   = (beat_cnt == cmd_len);
  // Oversize bursts are drained without being stored.
  assign fifo_push  = w_hs & ~err_len;
  // The core may only pop once it owns the command.
  assign fifo_pop   = (state == ST_WAIT) & wd_rd_en;
  // Data the core did not consume is stale once the burst is done.
  assign fifo_flush = (state == ST_WAIT) & wr_done & ~fifo_empty;

  axi_wdata_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_wdata_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (fifo_flush),
    .push  (fifo_push),
    .din   (wdata),
    .pop   (fifo_pop),
    .dout  (wd_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      awready   <= 1'b0;
      cmd_addr  <= '0;
      cmd_len   <= '0;
      beat_cnt  <= '0;
      err_len   <= 1'b0;
      err_last  <= 1'b0;
    end else begin
      state <= state_n;
      // Registered so awready stays low through reset and rises the cycle after B completes.
      awready <= (state_n == ST_IDLE);
      if (aw_hs) begin
        cmd_addr <= awaddr;
        cmd_len  <= awlen;
        beat_cnt <= '0;
        err_last <= 1'b0;
        err_len  <= len_too_long(awlen, FIFO_DEPTH);
      end
      if (w_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
        // wlast must coincide exactly with the counted end beat.
        if (end_beat != wlast) err_last <= 1'b1;
      end
      if (fifo_flush) err_last <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    wready    = 1'b0;
    cmd_valid = 1'b0;
    bvalid    = 1'b0;
    bresp     = BRESP_OKAY;
    case (state)
      ST_IDLE: begin
        if (aw_hs) state_n = ST_DATA;
      end
      ST_DATA: begin
        wready = err_len | ~fifo_full;
        // The beat count, not wlast, ends the burst.
        if (w_hs && end_beat) state_n = err_len ? ST_RESP : ST_CMD;
      end
      ST_CMD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (wr_done) state_n = ST_RESP;
      end
      ST_RESP: begin
        bvalid = 1'b1;
        bresp  = (err_len | err_last) ? BRESP_SLVERR : BRESP_OKAY;
        if (bready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
